mult_iter: RTL and testbench
============================

MULT_ITER -- requirements
Module: mult_iter

Interface
REQ-001 Parameter N, default 4: width of operand mult1, N >= 2.
REQ-002 Parameter M, default 4: width of operand mult2, M >= 2.
REQ-003 Parameter K, default 1: multiplier bits consumed per iteration, 1 <= K <= M; ITER = ceil(M/K).
REQ-004 clk  input  1: single clock, all state updates on its rising edge.
REQ-005 rstn  input  1: asynchronous, active-low reset.
REQ-006 in_valid  input  1: operands present on mult1/mult2.
REQ-007 in_ready  output  1: block can accept operands.
REQ-008 mult1  input  N: multiplicand.
REQ-009 mult2  input  M: multiplier.
REQ-010 mult_signed  input  1: operands are two's complement when 1; present only when MULT_SIGNED_EN is defined.
REQ-011 out_valid  output  1: result holds a valid product.
REQ-012 out_ready  input  1: downstream accepts the result.
REQ-013 result  output  N+M: product.
REQ-014 busy  output  1: high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, CALC, DONE; IDLE -> CALC on accept; CALC -> DONE after ITER iterations; DONE -> IDLE on out_ready.
REQ-016 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready.
REQ-017 On accept, mult1, mult2 and mult_signed SHALL be captured; later input changes SHALL not affect the operation.
REQ-018 in_valid in CALC or DONE SHALL be ignored with no side effect.
REQ-019 Each CALC cycle SHALL add the shifted multiplicand times the next K multiplier bits, LSB-first, to an N+M-bit accumulator.
REQ-020 An iteration counter SHALL run 0..ITER-1 and clear on leaving CALC; it SHALL not wrap within an operation.
REQ-021 When K does not divide M, the top iteration SHALL use zero-extended (unsigned) or sign-extended (signed) multiplier bits.
REQ-022 Latency: out_valid SHALL rise exactly ITER rising edges after the accept edge.
REQ-023 In DONE, result and out_valid SHALL stay stable until out_ready is 1.
REQ-024 out_valid and result SHALL clear on the edge where out_valid && out_ready; result SHALL be 0 whenever out_valid is 0.
REQ-025 in_ready SHALL rise the cycle after the result handshake; no input/output overlap.
REQ-026 The unsigned product SHALL be exact in N+M bits; no truncation or overflow flag.
REQ-027 An operand of 0 SHALL still take the full ITER cycles.

Reset
REQ-028 rstn low SHALL immediately force state IDLE, counter 0, accumulator 0, result 0, out_valid 0, busy 0, in_ready 0.
REQ-029 in_ready SHALL be 1 from the first rising clk edge after rstn deasserts.
REQ-030 Reset during CALC or DONE SHALL discard the operation without emitting a result.

Configuration
REQ-031 Macro MULT_SIGNED_EN defined: mult_signed port exists; when it is 1, result SHALL be the exact two's-complement product, including -2^(N-1) x -2^(M-1).
REQ-032 MULT_SIGNED_EN undefined: mult_signed port and signed logic SHALL be absent; all operations are unsigned.
REQ-033 Latency and handshake SHALL be identical in both builds.

Verification
REQ-034 N=4,M=4,K=1: mult1=15, mult2=15 accepted -> out_valid after 4 edges, result=225 (8'hE1).
REQ-035 N=4,M=4,K=2: mult1=9, mult2=6 -> out_valid after 2 edges, result=54; repeat with K=3 (ITER=2), mult1=7, mult2=13 -> result=91.
REQ-036 Hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready 0, in_valid pulses ignored; then out_ready=1 -> in_ready=1 on the next cycle.
REQ-037 Assert rstn=0 mid-CALC -> outputs cleared asynchronously, no out_valid afterwards; next operation 3x5 -> 15.
REQ-038 MULT_SIGNED_EN, N=M=4, mult_signed=1: -8 x -8 -> 64 (8'h40); -8 x 7 -> -56 (8'hC8); mult_signed=0, 4'h8 x 4'h7 -> 56.
REQ-039 Back-to-back: in_valid held high with out_ready=1 -> one accept every ITER+2 cycles, every product correct.

Source files
------------

// File: rtl/mult_iter_if.sv
// Operand/result handshake bundle for mult_iter.
// The mult_signed wire only exists when MULT_SIGNED_EN is defined.
interface mult_iter_if #(
    parameter int N = 4,
    parameter int M = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     mult1;
    logic [M-1:0]     mult2;
`ifdef MULT_SIGNED_EN
    logic             mult_signed;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [N+M-1:0]   result;
    logic             busy;

`ifdef MULT_SIGNED_EN
    modport master (output in_valid, mult1, mult2, mult_signed, out_ready,
                    input  in_ready, out_valid, result, busy);
    modport slave  (input  in_valid, mult1, mult2, mult_signed, out_ready,
                    output in_ready, out_valid, result, busy);
`else
    modport master (output in_valid, mult1, mult2, out_ready,
                    input  in_ready, out_valid, result, busy);
    modport slave  (input  in_valid, mult1, mult2, out_ready,
                    output in_ready, out_valid, result, busy);
`endif
endinterface

// File: rtl/mult_iter.sv
// Iterative shift-add multiplier consuming K multiplier bits per cycle.
// Define MULT_SIGNED_EN to add two's-complement operation selected by mult_signed.
module mult_iter #(
    parameter int N = 4,
    parameter int M = 4,
    parameter int K = 1
) (
    input  logic        clk,
    input  logic        rstn,
    mult_iter_if.slave  bus
);
    localparam int ITER = (M + K - 1) / K;
    localparam int MW   = ITER * K;
    localparam int W    = N + M;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [MW-1:0]   mplier_q, mplier_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    result_q, result_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
`ifdef MULT_SIGNED_EN
    logic            signed_q, signed_d;
`endif

    logic            accept;
    logic            last_iter;
    logic [K-1:0]    digit;
    logic [W-1:0]    digit_ext;
    logic [W-1:0]    partial;

    assign accept    = bus.in_valid && in_ready_q;
    assign last_iter = (cnt_q == LAST);
    assign digit     = mplier_q[K-1:0];

    // Only the most significant digit carries negative weight in signed mode.
`ifdef MULT_SIGNED_EN
    assign digit_ext = (signed_q && last_iter) ? W'($signed(digit)) : W'(digit);
`else
    assign digit_ext = W'(digit);
`endif
    assign partial   = mcand_q * digit_ext;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
`ifdef MULT_SIGNED_EN
        signed_d    = signed_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    acc_d   = '0;
`ifdef MULT_SIGNED_EN
                    signed_d = bus.mult_signed;
                    mcand_d  = bus.mult_signed ? W'($signed(bus.mult1))  : W'(bus.mult1);
                    mplier_d = bus.mult_signed ? MW'($signed(bus.mult2)) : MW'(bus.mult2);
`else
                    mcand_d  = W'(bus.mult1);
                    mplier_d = MW'(bus.mult2);
`endif
                end
            end
            CALC: begin
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << K;
                mplier_d = mplier_q >> K;
                if (last_iter) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    result_d    = acc_q + partial;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    result_d    = '0;
                    acc_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so that ready stays low while reset is asserted.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
            signed_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef MULT_SIGNED_EN
            signed_q    <= signed_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mult_iter.sv
// Bench for mult_iter: three instances (K=1,2,3; N=M=4) checked every cycle
// against a transaction-level model, plus hand-computed directed expectations.
module tb_mult_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn;
    logic [2:0]       in_valid, in_ready, out_valid, out_ready, busy, msg;
    logic [2:0][3:0]  mult1, mult2;
    logic [2:0][7:0]  result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            mult_iter_if #(.N(4), .M(4)) bus ();
            assign bus.in_valid  = in_valid[gi];
            assign bus.mult1     = mult1[gi];
            assign bus.mult2     = mult2[gi];
`ifdef MULT_SIGNED_EN
            assign bus.mult_signed = msg[gi];
`endif
            assign bus.out_ready = out_ready[gi];
            assign in_ready[gi]  = bus.in_ready;
            assign out_valid[gi] = bus.out_valid;
            assign result[gi]    = bus.result;
            assign busy[gi]      = bus.busy;
            mult_iter #(.N(4), .M(4), .K(gi + 1)) dut (
                .clk  (clk),
                .rstn (rstn),
                .bus  (bus)
            );
        end
    endgenerate

    function automatic int iter_of(input int i);
        return (4 + i) / (i + 1);   // ceil(4 / K) with K = i + 1
    endfunction

    function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b,
                                            input logic sg);
        int va, vb, p;
        va = (sg && a[3]) ? int'(a) - 16 : int'(a);
        vb = (sg && b[3]) ? int'(b) - 16 : int'(b);
        p  = va * vb;
        return p[7:0];
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [K=%0d] got %0h expected %0h at t=%0t",
                     name, idx + 1, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding op per instance, result due ITER edges after accept.
    logic       m_ready [3];
    logic       m_valid [3];
    logic       m_busy  [3];
    int         m_cnt   [3];
    logic [7:0] m_res   [3];
    logic [7:0] m_exp   [3];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 3; i++) begin
                m_ready[i] <= 1'b0;
                m_valid[i] <= 1'b0;
                m_busy[i]  <= 1'b0;
                m_cnt[i]   <= 0;
                m_res[i]   <= 8'h00;
                m_exp[i]   <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic sg;
`ifdef MULT_SIGNED_EN
                sg = msg[i];
`else
                sg = 1'b0;
`endif
                if (m_valid[i]) begin
                    if (out_ready[i]) begin
                        m_valid[i] <= 1'b0;
                        m_res[i]   <= 8'h00;
                        m_ready[i] <= 1'b1;
                        m_busy[i]  <= 1'b0;
                    end
                end else if (m_cnt[i] != 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_valid[i] <= 1'b1;
                        m_res[i]   <= m_exp[i];
                    end
                end else if (m_ready[i]) begin
                    if (in_valid[i]) begin
                        m_ready[i] <= 1'b0;
                        m_busy[i]  <= 1'b1;
                        m_cnt[i]   <= iter_of(i);
                        m_exp[i]   <= ref_prod(mult1[i], mult2[i], sg);
                    end
                end else begin
                    m_ready[i] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                check("cyc_in_ready",  i, 8'(in_ready[i]),  8'(m_ready[i]));
                check("cyc_out_valid", i, 8'(out_valid[i]), 8'(m_valid[i]));
                check("cyc_busy",      i, 8'(busy[i]),      8'(m_busy[i]));
                check("cyc_result",    i, result[i],        m_res[i]);
            end
        end
    end

    task automatic wait_ready(input int idx);
        int n = 0;
        while (!in_ready[idx] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", idx, 8'(in_ready[idx]), 8'h01);
    endtask

    task automatic do_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                         input logic sg, input logic [7:0] exp_lit, input int lat_lit);
        int n;
        wait_ready(idx);
        mult1[idx] = a; mult2[idx] = b; msg[idx] = sg; in_valid[idx] = 1'b1;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0; mult1[idx] = ~a; mult2[idx] = ~b; msg[idx] = ~sg;
        n = 0;
        while (!out_valid[idx] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", idx, 8'(n), 8'(lat_lit));
        check("result",  idx, result[idx], exp_lit);
        $display("op K=%0d %0h x %0h signed=%0b -> %0h after %0d edges",
                 idx + 1, a, b, sg, result[idx], n);
        @(posedge clk); #1;
    endtask

    task automatic b2b(input int idx, input int period_lit);
        logic [3:0] ta [4] = '{4'd15, 4'd3, 4'd0, 4'd11};
        logic [3:0] tb [4] = '{4'd14, 4'd5, 4'd9, 4'd13};
        int last = 0;
        int n;
        in_valid[idx] = 1'b1;
        out_ready[idx] = 1'b1;
        msg[idx] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            mult1[idx] = ta[j]; mult2[idx] = tb[j];
            n = 0;
            while (!in_ready[idx] && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            @(posedge clk); #1;
            if (j == 3) in_valid[idx] = 1'b0;
            if (j > 0) check("b2b_period", idx, 8'(cyc - last), 8'(period_lit));
            $display("b2b K=%0d accept %0h x %0h at cycle %0d", idx + 1, ta[j], tb[j], cyc);
            last = cyc;
        end
        repeat (period_lit + 1) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        in_valid = '0; mult1 = '0; mult2 = '0; msg = '0;
        out_ready = '1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready",  i, 8'(in_ready[i]),  8'h00);
            check("rst_out_valid", i, 8'(out_valid[i]), 8'h00);
            check("rst_busy",      i, 8'(busy[i]),      8'h00);
            check("rst_result",    i, result[i],        8'h00);
        end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 0, 8'(in_ready[0]), 8'h01);

        do_op(0, 4'd15, 4'd15, 1'b0, 8'hE1, 4);
        do_op(1, 4'd9,  4'd6,  1'b0, 8'd54, 2);
        do_op(2, 4'd7,  4'd13, 1'b0, 8'd91, 2);
        do_op(2, 4'd15, 4'd15, 1'b0, 8'hE1, 2);
        do_op(0, 4'd0,  4'd13, 1'b0, 8'd0,  4);
        do_op(1, 4'd0,  4'd0,  1'b0, 8'd0,  2);
`ifdef MULT_SIGNED_EN
        do_op(0, 4'h8, 4'h8, 1'b1, 8'h40, 4);
        do_op(0, 4'h8, 4'h7, 1'b1, 8'hC8, 4);
        do_op(1, 4'h8, 4'h8, 1'b1, 8'h40, 2);
        do_op(2, 4'h8, 4'h7, 1'b1, 8'hC8, 2);
        do_op(2, 4'h8, 4'h8, 1'b1, 8'h40, 2);
        do_op(0, 4'h8, 4'h7, 1'b0, 8'h38, 4);
`endif

        // Result held under back-pressure; in_valid pulses must be ignored.
        out_ready[0] = 1'b0;
        wait_ready(0);
        mult1[0] = 4'd15; mult2[0] = 4'd15; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        begin
            int n = 0;
            while (!out_valid[0] && n < 40) begin @(posedge clk); #1; n++; end
        end
        for (int c = 0; c < 5; c++) begin
            in_valid[0] = c[0]; mult1[0] = 4'd3; mult2[0] = 4'd3;
            @(posedge clk); #1;
            check("hold_result",    0, result[0],          8'hE1);
            check("hold_out_valid", 0, 8'(out_valid[0]),   8'h01);
            check("hold_in_ready",  0, 8'(in_ready[0]),    8'h00);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready",  0, 8'(in_ready[0]),  8'h01);
        check("release_out_valid", 0, 8'(out_valid[0]), 8'h00);
        check("release_result",    0, result[0],        8'h00);
        $display("hold K=1 15 x 15 held 5 cycles then released");

        // Reset in the middle of a calculation.
        wait_ready(0);
        mult1[0] = 4'd15; mult2[0] = 4'd15; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", 0, 8'(busy[0]), 8'h01);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_busy",      0, 8'(busy[0]),      8'h00);
        check("async_rst_in_ready",  0, 8'(in_ready[0]),  8'h00);
        check("async_rst_out_valid", 0, 8'(out_valid[0]), 8'h00);
        check("async_rst_result",    0, result[0],        8'h00);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("no_result_after_rst", 0, 8'(out_valid[0]), 8'h00);
        end
        $display("reset K=1 mid-calc discarded");
        do_op(0, 4'd3, 4'd5, 1'b0, 8'd15, 4);

        b2b(1, 4);
        b2b(0, 6);
        b2b(2, 4);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
